// File: rtl/trap_arbiter_if.sv
// Bundle of trap-source, CPU write and mode-FSM signals seen by trap_arbiter.
// master drives events and CPU writes; slave is the arbiter itself.
interface trap_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0] src_req;
    logic               trap_state;
    logic               mask_wr;
    logic               ack_wr;
    logic [7:0]         wr_data;
    logic               trap_condition;
    logic [2:0]         cause;
    logic               cause_valid;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic               overrun;

    modport master (
        output src_req, trap_state, mask_wr, ack_wr, wr_data,
        input  trap_condition, cause, cause_valid, pending, mask, overrun
    );

    modport slave (
        input  src_req, trap_state, mask_wr, ack_wr, wr_data,
        output trap_condition, cause, cause_valid, pending, mask, overrun
    );
endinterface

// File: rtl/trap_arbiter.sv
// Merges edge-triggered trap sources into a single trap request with a frozen
// priority cause, one trap in flight and a hold-off gap between traps.
module trap_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int HOLDOFF = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    trap_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, ACTIVE, HOLD} state_t;

    localparam int         HOLD_LOAD_I = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
    localparam logic [7:0] HOLD_LOAD   = HOLD_LOAD_I[7:0];

    state_t             state_q;
    logic [7:0]         hold_cnt_q;
    logic               trap_condition_q;
    logic [2:0]         cause_q;
    logic               cause_valid_q;
    logic [NUM_SRC-1:0] src_prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               overrun_q, overrun_d;

    logic [NUM_SRC-1:0] riseEvt;
    logic [NUM_SRC-1:0] acceptEvt;
    logic [NUM_SRC-1:0] ackClr;
    logic [NUM_SRC-1:0] eligible;
    logic [2:0]         winner;
    logic               unusedWrBits;

    assign unusedWrBits = ^bus.wr_data;

    // A new event always beats a same-cycle software clear, for both pending and overrun.
    always_comb begin
        riseEvt   = bus.src_req & ~src_prev_q;
        acceptEvt = riseEvt & mask_q;
        ackClr    = bus.ack_wr ? bus.wr_data[NUM_SRC-1:0] : '0;
        pending_d = (pending_q & ~ackClr) | acceptEvt;
        overrun_d = (overrun_q & ~(bus.ack_wr & bus.wr_data[7])) | (|(acceptEvt & pending_q));
        mask_d    = bus.mask_wr ? bus.wr_data[NUM_SRC-1:0] : mask_q;
        eligible  = pending_q & mask_q;
        winner    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            src_prev_q <= bus.src_req;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            overrun_q  <= overrun_d;
        end
    end

    // Priority is sampled only when leaving IDLE; cause stays frozen until the next trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            hold_cnt_q       <= '0;
            trap_condition_q <= 1'b0;
            cause_q          <= '0;
            cause_valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((|eligible) && !bus.trap_state) begin
                        cause_q          <= winner;
                        cause_valid_q    <= 1'b1;
                        trap_condition_q <= 1'b1;
                        state_q          <= REQ;
                    end
                end
                REQ: begin
                    if (bus.trap_state) begin
                        trap_condition_q <= 1'b0;
                        state_q          <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!bus.trap_state) begin
                        cause_valid_q <= 1'b0;
                        hold_cnt_q    <= HOLD_LOAD;
                        state_q       <= (HOLDOFF == 0) ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == 8'd0) begin
                        state_q <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.trap_condition = trap_condition_q;
    assign bus.cause          = cause_q;
    assign bus.cause_valid    = cause_valid_q;
    assign bus.pending        = pending_q;
    assign bus.mask           = mask_q;
    assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_trap_arbiter.sv
// Directed and randomized bench for trap_arbiter, checked each cycle against a
// cycle-count based behavioural model of trap issue, hold-off and event capture.
module tb_trap_arbiter;
    localparam int NUM_SRC = 4;
    localparam int HOLDOFF = 8;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;
    int   failCount;

    trap_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

    trap_arbiter #(.NUM_SRC(NUM_SRC), .HOLDOFF(HOLDOFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: a trap is "in flight" from issue until trap_state is seen high then low;
    // a new trap may not issue before cycle readyAt.
    logic [NUM_SRC-1:0] mPend, mMask, mPrev;
    logic               mOv, mCond, mValid, mInFlight, mSeenHigh;
    logic [2:0]         mCause;
    int                 cycleNo;
    int                 mReadyAt;

    task automatic modelReset();
        mPend = '0; mMask = '0; mPrev = '0; mOv = 1'b0;
        mCond = 1'b0; mValid = 1'b0; mCause = '0;
        mInFlight = 1'b0; mSeenHigh = 1'b0; mReadyAt = 0;
    endtask

    function automatic logic [2:0] lowestIndex(input logic [NUM_SRC-1:0] v);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic modelStep();
        logic [NUM_SRC-1:0] rise, acc, elig;
        rise = bus.src_req & ~mPrev;
        acc  = rise & mMask;
        elig = mPend & mMask;
        if (!mInFlight && cycleNo >= mReadyAt && elig != 0 && !bus.trap_state) begin
            mCause = lowestIndex(elig); mValid = 1'b1; mCond = 1'b1;
            mInFlight = 1'b1; mSeenHigh = 1'b0;
        end else if (mInFlight && !mSeenHigh && bus.trap_state) begin
            mSeenHigh = 1'b1; mCond = 1'b0;
        end else if (mInFlight && mSeenHigh && !bus.trap_state) begin
            mValid = 1'b0; mInFlight = 1'b0; mReadyAt = cycleNo + HOLDOFF + 1;
        end
        if (bus.ack_wr && bus.wr_data[7]) mOv = 1'b0;
        if ((acc & mPend) != 0) mOv = 1'b1;
        if (bus.ack_wr) mPend = mPend & ~bus.wr_data[NUM_SRC-1:0];
        mPend = mPend | acc;
        if (bus.mask_wr) mMask = bus.wr_data[NUM_SRC-1:0];
        mPrev = bus.src_req;
        cycleNo++;
    endtask

    task automatic checkVal(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_cond"},    8'(bus.trap_condition), 8'(mCond));
        checkVal({tag, "_cause"},   8'(bus.cause),          8'(mCause));
        checkVal({tag, "_valid"},   8'(bus.cause_valid),    8'(mValid));
        checkVal({tag, "_pending"}, 8'(bus.pending),        8'(mPend));
        checkVal({tag, "_mask"},    8'(bus.mask),           8'(mMask));
        checkVal({tag, "_overrun"}, 8'(bus.overrun),        8'(mOv));
    endtask

    task automatic applyStimulus(input logic [NUM_SRC-1:0] src, input logic ts,
                                 input logic maskWr, input logic ackWr, input logic [7:0] data);
        bus.src_req    = src;
        bus.trap_state = ts;
        bus.mask_wr    = maskWr;
        bus.ack_wr     = ackWr;
        bus.wr_data    = data;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput(tag);
        bus.mask_wr = 1'b0;
        bus.ack_wr  = 1'b0;
    endtask

    initial begin
        logic [NUM_SRC-1:0] srcV;
        logic               tsV;
        checkCount = 0; passCount = 0; failCount = 0; cycleNo = 0;
        modelReset();
        rst_n = 1'b0;
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 8'h00);
        #3;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single source trap");
        applyStimulus(4'h0, 1'b0, 1'b1, 1'b0, 8'h0F); tick("t1_mask");
        checkVal("t1_mask_val", 8'(bus.mask), 8'h0F);
        applyStimulus(4'h4, 1'b0, 1'b0, 1'b0, 8'h00); tick("t1_edge");
        checkVal("t1_pending", 8'(bus.pending), 8'h04);
        checkVal("t1_cond_early", 8'(bus.trap_condition), 8'h00);
        tick("t1_issue");
        checkVal("t1_cond", 8'(bus.trap_condition), 8'h01);
        checkVal("t1_cause", 8'(bus.cause), 8'h02);
        checkVal("t1_valid", 8'(bus.cause_valid), 8'h01);
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 8'h00); tick("t1_ack_state");
        checkVal("t3_cond_drop", 8'(bus.trap_condition), 8'h00);
        checkVal("t3_valid_held", 8'(bus.cause_valid), 8'h01);
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b1, 8'h04); tick("t1_ackwr");
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 8'h00); tick("t1_release");
        checkVal("t3_valid_clear", 8'(bus.cause_valid), 8'h00);
        repeat (10) tick("t1_hold");

        $display("[TB] simultaneous sources and hold-off");
        applyStimulus(4'hA, 1'b0, 1'b0, 1'b0, 8'h00); tick("t2_edge");
        checkVal("t2_pending", 8'(bus.pending), 8'h0A);
        tick("t2_issue");
        checkVal("t2_cause1", 8'(bus.cause), 8'h01);
        checkVal("t2_cond1", 8'(bus.trap_condition), 8'h01);
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 8'h00); tick("t2_active");
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b1, 8'h02); tick("t2_ackwr");
        checkVal("t2_pending_after_ack", 8'(bus.pending), 8'h08);
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 8'h00); tick("t2_release");
        checkVal("t2_valid_clear", 8'(bus.cause_valid), 8'h00);
        for (int i = 0; i < HOLDOFF; i++) begin
            tick("t2_hold");
            checkVal("t3_holdoff_quiet", 8'(bus.trap_condition), 8'h00);
        end
        tick("t2_reissue");
        checkVal("t2_cond3", 8'(bus.trap_condition), 8'h01);
        checkVal("t2_cause3", 8'(bus.cause), 8'h03);
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 8'h00); tick("t2_active2");
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b1, 8'h08); tick("t2_ackwr2");
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 8'h00); tick("t2_release2");
        repeat (10) tick("t2_hold2");

        $display("[TB] masking and overrun");
        applyStimulus(4'h0, 1'b0, 1'b1, 1'b0, 8'h00); tick("t4_mask0");
        applyStimulus(4'h1, 1'b0, 1'b0, 1'b0, 8'h00); tick("t4_masked_edge");
        tick("t4_wait");
        checkVal("t4_masked_pending", 8'(bus.pending), 8'h00);
        checkVal("t4_masked_cond", 8'(bus.trap_condition), 8'h00);
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 8'h00); tick("t4_low");
        applyStimulus(4'h0, 1'b0, 1'b1, 1'b0, 8'h01); tick("t4_mask1");
        applyStimulus(4'h1, 1'b0, 1'b0, 1'b0, 8'h00); tick("t4_edge1");
        checkVal("t4_pending1", 8'(bus.pending), 8'h01);
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 8'h00); tick("t4_low2");
        applyStimulus(4'h1, 1'b0, 1'b0, 1'b0, 8'h00); tick("t4_edge2");
        checkVal("t4_overrun_set", 8'(bus.overrun), 8'h01);
        applyStimulus(4'h1, 1'b0, 1'b0, 1'b1, 8'h80); tick("t4_clr_ovr");
        checkVal("t4_overrun_clr", 8'(bus.overrun), 8'h00);
        checkVal("t4_pending_kept", 8'(bus.pending), 8'h01);

        $display("[TB] set beats clear");
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 8'h00); tick("t5_low");
        applyStimulus(4'h1, 1'b0, 1'b0, 1'b1, 8'h01); tick("t5_race");
        checkVal("t5_pending_set_wins", 8'(bus.pending), 8'h01);

        $display("[TB] async reset in REQ");
        checkVal("t6_in_req", 8'(bus.trap_condition), 8'h01);
        #2 rst_n = 1'b0;
        #1;
        checkVal("t6_cond", 8'(bus.trap_condition), 8'h00);
        checkVal("t6_valid", 8'(bus.cause_valid), 8'h00);
        checkVal("t6_pending", 8'(bus.pending), 8'h00);
        checkVal("t6_mask", 8'(bus.mask), 8'h00);
        modelReset();
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] trap_state blocks issue");
        applyStimulus(4'h0, 1'b1, 1'b1, 1'b0, 8'h0F); tick("t7_mask");
        applyStimulus(4'h2, 1'b1, 1'b0, 1'b0, 8'h00); tick("t7_edge");
        for (int i = 0; i < 4; i++) begin
            tick("t7_blocked");
            checkVal("t7_no_request", 8'(bus.trap_condition), 8'h00);
        end
        applyStimulus(4'h2, 1'b0, 1'b0, 1'b0, 8'h00); tick("t7_unblock");
        checkVal("t7_cond", 8'(bus.trap_condition), 8'h01);
        checkVal("t7_cause", 8'(bus.cause), 8'h01);
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 8'h00); tick("t7_active");
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b1, 8'h0F); tick("t7_ackwr");
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 8'h00); tick("t7_release");
        repeat (10) tick("t7_hold");

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            srcV = ($urandom_range(0, 2) == 0) ? NUM_SRC'($urandom) : bus.src_req;
            tsV  = bus.trap_state;
            if (mCond && !tsV && $urandom_range(0, 2) == 0) tsV = 1'b1;
            else if (tsV && !mCond && $urandom_range(0, 3) == 0) tsV = 1'b0;
            else if (!tsV && !mInFlight && $urandom_range(0, 19) == 0) tsV = 1'b1;
            applyStimulus(srcV, tsV, ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                          8'($urandom));
            tick("rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
